// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared encodings and default states for the control-unit microsequencer
package cu_pkg;

  localparam logic [2:0] NS_ENCODE = 3'b000;
  localparam logic [2:0] NS_INC    = 3'b001;
  localparam logic [2:0] NS_JUMP   = 3'b010;
  localparam logic [2:0] NS_CJUMP  = 3'b011;
  localparam logic [2:0] NS_FETCH  = 3'b100;

  localparam logic [1:0] CSEL_MOC  = 2'b00;
  localparam logic [1:0] CSEL_COND = 2'b01;
  localparam logic [1:0] CSEL_ZERO = 2'b10;
  localparam logic [1:0] CSEL_ONE  = 2'b11;

  localparam int DEF_RESET_STATE = 0;
  localparam int DEF_FETCH_STATE = 1;
  localparam int DEF_ABORT_STATE = 3;

endpackage

// File: rtl/next_state_sel.sv
// rtl/next_state_sel.sv - combinational next-address mux with condition select/invert
module next_state_sel
  import cu_pkg::*;
#(
  parameter int STATE_W     = 7,
  parameter int FETCH_STATE = DEF_FETCH_STATE,
  parameter int ABORT_STATE = DEF_ABORT_STATE
) (
  input  logic [2:0]         ctrl_ns,
  input  logic [STATE_W-1:0] ctrl_cr,
  input  logic [1:0]         ctrl_csel,
  input  logic               ctrl_inv,
  input  logic               moc,
  input  logic               cond_true,
  input  logic [STATE_W-1:0] enc_state,
  input  logic [STATE_W-1:0] state_inc,
  output logic [STATE_W-1:0] next_state,
  output logic               undef_trap
);

  localparam logic [STATE_W-1:0] FETCH_S = STATE_W'(FETCH_STATE);
  localparam logic [STATE_W-1:0] ABORT_S = STATE_W'(ABORT_STATE);

  logic sel_cond;

  always_comb begin
    sel_cond = 1'b0;
    case (ctrl_csel)
      CSEL_MOC:  sel_cond = moc;
      CSEL_COND: sel_cond = cond_true;
      CSEL_ZERO: sel_cond = 1'b0;
      default:   sel_cond = 1'b1;
    endcase
  end

  always_comb begin
    next_state = ABORT_S;
    undef_trap = 1'b0;
    case (ctrl_ns)
      NS_ENCODE: begin
        // A failed condition skips the instruction; encoder code 0 means undefined.
        if (!cond_true) begin
          next_state = FETCH_S;
        end else if (enc_state == '0) begin
          next_state = ABORT_S;
          undef_trap = 1'b1;
        end else begin
          next_state = enc_state;
        end
      end
      NS_INC:   next_state = state_inc;
      NS_JUMP:  next_state = ctrl_cr;
      NS_CJUMP: next_state = (sel_cond ^ ctrl_inv) ? ctrl_cr : state_inc;
      NS_FETCH: next_state = FETCH_S;
      default:  next_state = ABORT_S;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - microstate register with MOC wait/timeout and undefined-instruction trap
module microsequencer
  import cu_pkg::*;
#(
  parameter int STATE_W     = 7,
  parameter int RESET_STATE = DEF_RESET_STATE,
  parameter int FETCH_STATE = DEF_FETCH_STATE,
  parameter int ABORT_STATE = DEF_ABORT_STATE,
  parameter int MOC_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               cond_true,
  input  logic               moc,
  input  logic [2:0]         ctrl_ns,
  input  logic [STATE_W-1:0] ctrl_cr,
  input  logic [1:0]         ctrl_csel,
  input  logic               ctrl_inv,
  input  logic               ctrl_mfa,
  output logic [STATE_W-1:0] state,
  output logic               mem_wait,
  output logic               mem_fault,
  output logic               undef
);

  localparam logic [STATE_W-1:0] RESET_S = STATE_W'(RESET_STATE);
  localparam logic [STATE_W-1:0] ABORT_S = STATE_W'(ABORT_STATE);
  localparam logic [7:0]         TMO     = 8'(MOC_TIMEOUT);

  logic [STATE_W-1:0] state_q, state_d, state_inc, sel_next;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               mem_fault_q, mem_fault_d;
  logic               undef_q, undef_d;
  logic               sel_undef, mem_timeout;

  assign state_inc   = state_q + STATE_W'(1);
  assign mem_wait    = ctrl_mfa & ~moc & (wait_cnt_q < TMO);
  assign mem_timeout = ctrl_mfa & ~moc & ~(wait_cnt_q < TMO);

  next_state_sel #(
    .STATE_W     (STATE_W),
    .FETCH_STATE (FETCH_STATE),
    .ABORT_STATE (ABORT_STATE)
  ) u_sel (
    .ctrl_ns    (ctrl_ns),
    .ctrl_cr    (ctrl_cr),
    .ctrl_csel  (ctrl_csel),
    .ctrl_inv   (ctrl_inv),
    .moc        (moc),
    .cond_true  (cond_true),
    .enc_state  (enc_state),
    .state_inc  (state_inc),
    .next_state (sel_next),
    .undef_trap (sel_undef)
  );

  // Memory hold outranks the microcode's own next-state choice.
  always_comb begin
    state_d     = sel_next;
    wait_cnt_d  = '0;
    mem_fault_d = 1'b0;
    undef_d     = 1'b0;
    if (mem_wait) begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else if (mem_timeout) begin
      state_d     = ABORT_S;
      mem_fault_d = 1'b1;
    end else begin
      undef_d = sel_undef;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_S;
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
      undef_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= mem_fault_d;
      undef_q     <= undef_d;
    end
  end

  assign state     = state_q;
  assign mem_fault = mem_fault_q;
  assign undef     = undef_q;

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - scoreboard bench for the microsequencer
module tb_microsequencer;
  import cu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] enc_state, ctrl_cr, state;
  logic       cond_true, moc, ctrl_inv, ctrl_mfa;
  logic [2:0] ctrl_ns;
  logic [1:0] ctrl_csel;
  logic       mem_wait, mem_fault, undef;

  typedef struct packed {
    logic [6:0] st;
    logic       w;
    logic       f;
    logic       u;
    logic [31:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   step = 0;

  microsequencer dut (
    .clk       (clk),
    .reset     (reset),
    .enc_state (enc_state),
    .cond_true (cond_true),
    .moc       (moc),
    .ctrl_ns   (ctrl_ns),
    .ctrl_cr   (ctrl_cr),
    .ctrl_csel (ctrl_csel),
    .ctrl_inv  (ctrl_inv),
    .ctrl_mfa  (ctrl_mfa),
    .state     (state),
    .mem_wait  (mem_wait),
    .mem_fault (mem_fault),
    .undef     (undef)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st) begin
        failures++;
        $display("FAIL step%0d state got=%0d exp=%0d", e.id, state, e.st);
      end
      checks++;
      if (mem_wait !== e.w) begin
        failures++;
        $display("FAIL step%0d mem_wait got=%b exp=%b", e.id, mem_wait, e.w);
      end
      checks++;
      if (mem_fault !== e.f) begin
        failures++;
        $display("FAIL step%0d mem_fault got=%b exp=%b", e.id, mem_fault, e.f);
      end
      checks++;
      if (undef !== e.u) begin
        failures++;
        $display("FAIL step%0d undef got=%b exp=%b", e.id, undef, e.u);
      end
    end
  end

  // Apply one cycle of inputs and queue the outputs expected during that cycle.
  task automatic cyc(input logic rst, input logic [2:0] ns, input logic [6:0] cr,
                     input logic [1:0] csel, input logic inv, input logic mfa,
                     input logic m, input logic c, input logic [6:0] enc,
                     input logic [6:0] est, input logic ew, input logic ef, input logic eu);
    exp_t e;
    reset = rst; ctrl_ns = ns; ctrl_cr = cr; ctrl_csel = csel; ctrl_inv = inv;
    ctrl_mfa = mfa; moc = m; cond_true = c; enc_state = enc;
    step++;
    e.st = est; e.w = ew; e.f = ef; e.u = eu; e.id = 32'(step);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ctrl_ns = NS_INC; ctrl_cr = '0; ctrl_csel = CSEL_ZERO; ctrl_inv = 1'b0;
    ctrl_mfa = 1'b0; moc = 1'b0; cond_true = 1'b0; enc_state = '0;
    @(posedge clk);
    #1;
    // reset and release
    cyc(1, NS_JUMP, 7'd99, CSEL_ONE, 0, 0, 0, 0, 0,  7'd0, 0, 0, 0);
    cyc(0, NS_INC,  7'd0,  CSEL_ZERO, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0);
    // encode paths
    cyc(0, NS_ENCODE, 0, CSEL_ZERO, 0, 0, 0, 1, 7'd7, 7'd1, 0, 0, 0);
    cyc(0, NS_FETCH,  0, CSEL_ZERO, 0, 0, 0, 0, 7'd0, 7'd7, 0, 0, 0);
    cyc(0, NS_ENCODE, 0, CSEL_ZERO, 0, 0, 0, 0, 7'd7, 7'd1, 0, 0, 0);
    cyc(0, NS_ENCODE, 0, CSEL_ZERO, 0, 0, 0, 1, 7'd0, 7'd1, 0, 0, 0);
    cyc(0, NS_FETCH,  0, CSEL_ZERO, 0, 0, 0, 0, 7'd0, 7'd3, 0, 0, 1);
    cyc(0, NS_JUMP, 7'd10, CSEL_ZERO, 0, 0, 0, 0, 0, 7'd1, 0, 0, 0);
    // four-cycle memory wait then moc
    for (int i = 0; i < 4; i++) cyc(0, NS_INC, 0, CSEL_ZERO, 0, 1, 0, 0, 0, 7'd10, 1, 0, 0);
    cyc(0, NS_INC,  0,     CSEL_ZERO, 0, 1, 1, 0, 0, 7'd10, 0, 0, 0);
    cyc(0, NS_JUMP, 7'd20, CSEL_ZERO, 0, 0, 0, 0, 0, 7'd11, 0, 0, 0);
    // moc never arrives: timeout after 15 wait cycles
    for (int i = 0; i < 15; i++) cyc(0, NS_INC, 0, CSEL_ZERO, 0, 1, 0, 0, 0, 7'd20, 1, 0, 0);
    cyc(0, NS_INC,   0,      CSEL_ZERO, 0, 1, 0, 0, 0, 7'd20, 0, 0, 0);
    cyc(0, NS_FETCH, 0,      CSEL_ZERO, 0, 0, 0, 0, 0, 7'd3,  0, 1, 0);
    cyc(0, NS_JUMP,  7'd127, CSEL_ZERO, 0, 0, 0, 0, 0, 7'd1,  0, 0, 0);
    // wrap, conditional jumps, illegal ns
    cyc(0, NS_INC,   0,     CSEL_ZERO, 0, 0, 0, 0, 0, 7'd127, 0, 0, 0);
    cyc(0, NS_CJUMP, 7'd40, CSEL_MOC,  1, 0, 0, 0, 0, 7'd0,   0, 0, 0);
    cyc(0, NS_CJUMP, 7'd40, CSEL_MOC,  1, 0, 1, 0, 0, 7'd40,  0, 0, 0);
    cyc(0, NS_CJUMP, 7'd50, CSEL_ONE,  0, 0, 0, 0, 0, 7'd41,  0, 0, 0);
    cyc(0, NS_CJUMP, 7'd60, CSEL_ZERO, 0, 0, 0, 0, 0, 7'd50,  0, 0, 0);
    cyc(0, 3'b101,   0,     CSEL_ZERO, 0, 0, 0, 1, 0, 7'd51,  0, 0, 0);
    cyc(0, NS_FETCH, 0,     CSEL_ZERO, 0, 0, 0, 0, 0, 7'd3,   0, 0, 0);
    // mfa combined with CJUMP on ~moc: hold dominates until moc
    cyc(0, NS_CJUMP, 7'd60, CSEL_MOC, 1, 1, 0, 0, 0, 7'd1, 1, 0, 0);
    cyc(0, NS_CJUMP, 7'd60, CSEL_MOC, 1, 1, 1, 0, 0, 7'd1, 0, 0, 0);
    cyc(0, NS_FETCH, 0,     CSEL_ZERO, 0, 0, 0, 0, 0, 7'd2, 0, 0, 0);
    cyc(0, NS_JUMP,  7'd30, CSEL_ZERO, 0, 0, 0, 0, 0, 7'd1, 0, 0, 0);
    // reset mid-wait at count 6, then a full-length wait proves the counter restarted
    for (int i = 0; i < 6; i++) cyc(0, NS_INC, 0, CSEL_ZERO, 0, 1, 0, 0, 0, 7'd30, 1, 0, 0);
    cyc(1, NS_INC,  0,     CSEL_ZERO, 0, 1, 0, 0, 0, 7'd30, 1, 0, 0);
    cyc(0, NS_JUMP, 7'd30, CSEL_ZERO, 0, 0, 0, 0, 0, 7'd0,  0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(0, NS_INC, 0, CSEL_ZERO, 0, 1, 0, 0, 0, 7'd30, 1, 0, 0);
    cyc(0, NS_INC,   0, CSEL_ZERO, 0, 1, 0, 0, 0, 7'd30, 0, 0, 0);
    cyc(0, NS_FETCH, 0, CSEL_ZERO, 0, 0, 0, 0, 0, 7'd3,  0, 1, 0);
    cyc(0, NS_FETCH, 0, CSEL_ZERO, 0, 0, 0, 0, 0, 7'd1,  0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
